// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART transmit path.
//   send_state_t : sender FSM states (S_IDLE, S_BUSY)
//   BYTE_W       : width of one transmitted byte
//   MARKER_DEF   : default end-of-frame marker byte
package uart_pkg;
  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] MARKER_DEF = 8'hA5;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } send_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo -- single-clock FIFO, W bits wide, DEPTH (power of two) entries.
// Ports:
//   clk, reset     : clock, synchronous active-low reset (empties the FIFO)
//   i_push/i_wdata : write request and data (caller never pushes when full)
//   i_pop          : read request (caller never pops when empty)
//   o_head         : entry at the read pointer (show-ahead)
//   o_count        : occupancy, 0..DEPTH
//   o_full/o_empty : occupancy flags
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [W-1:0]             i_wdata,
  input  logic                     i_pop,
  output logic [W-1:0]             o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;

  // Storage needs no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + AW'(1);
      if (i_pop)  r_rd <= r_rd + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
endmodule

// File: rtl/tx_pixel_packer.sv
// tx_pixel_packer -- packs a 1-bit pixel stream into bytes (pixel k -> bit k),
// buffers them in a FIFO and feeds a UART transmitter paced by tx_done_tick.
// Optional feature macro: FRAME_MARKER_EN (append MARKER after each frame).
// Ports:
//   clk, reset          : clock, synchronous active-low reset
//   pix_valid/pix_bit   : pixel handshake input, pix_last ends a frame
//   pix_ready           : pixel accepted this cycle (from registered state only)
//   tx_start, din       : one-cycle load strobe and byte for the transmitter
//   tx_done_tick        : transmitter finished the current byte
//   fifo_count          : bytes buffered
module tx_pixel_packer
  import uart_pkg::*;
#(
  parameter int                DEPTH  = 16,
  parameter logic [BYTE_W-1:0] MARKER = MARKER_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pix_valid,
  input  logic                   pix_bit,
  input  logic                   pix_last,
  output logic                   pix_ready,
  output logic                   tx_start,
  output logic [BYTE_W-1:0]      din,
  input  logic                   tx_done_tick,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [BYTE_W-1:0] r_pk;
  logic [2:0]        r_pidx;
  logic [BYTE_W-1:0] r_din;
  logic              r_tx_start;
  send_state_t       r_state;

  logic              w_xfer;
  logic [BYTE_W-1:0] w_byte;
  logic              w_pix_push;
  logic              w_push;
  logic [BYTE_W-1:0] w_wdata;
  logic              w_pop;
  logic [BYTE_W-1:0] w_head;
  logic [CW-1:0]     w_count;
  logic              w_full;
  logic              w_empty;

  assign w_xfer     = pix_valid & pix_ready;
  // Bits above pidx are still zero, so OR-ing in the new bit both merges it
  // and zero-pads a partial byte flushed by pix_last.
  assign w_byte     = r_pk | (BYTE_W'(pix_bit) << r_pidx);
  assign w_pix_push = w_xfer & ((r_pidx == 3'd7) | pix_last);

`ifdef FRAME_MARKER_EN
  logic r_mark_pend;

  always_ff @(posedge clk) begin
    if (!reset) r_mark_pend <= 1'b0;
    else        r_mark_pend <= w_pix_push & pix_last;
  end

  // Two free slots are held back so the marker always fits behind the last
  // data byte; the marker cycle itself takes the FIFO write port.
  assign w_push    = w_pix_push | r_mark_pend;
  assign w_wdata   = r_mark_pend ? MARKER : w_byte;
  assign pix_ready = ~r_mark_pend & ~w_full & (w_count <= CW'(DEPTH - 2));
`else
  logic w_unused_marker;
  assign w_unused_marker = ^MARKER;

  assign w_push    = w_pix_push;
  assign w_wdata   = w_byte;
  assign pix_ready = ~w_full;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pk   <= '0;
      r_pidx <= '0;
    end else if (w_xfer) begin
      if (w_pix_push) begin
        r_pk   <= '0;
        r_pidx <= '0;
      end else begin
        r_pk   <= w_byte;
        r_pidx <= r_pidx + 3'd1;
      end
    end
  end

  sync_fifo #(.W(BYTE_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // A tick coinciding with our own tx_start cannot belong to the byte just
  // loaded, so it is ignored; this also keeps tx_start from repeating.
  assign w_pop = ~w_empty &
                 ((r_state == S_IDLE) |
                  ((r_state == S_BUSY) & tx_done_tick & ~r_tx_start));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_tx_start <= 1'b0;
      r_din      <= '0;
    end else begin
      r_tx_start <= w_pop;
      if (w_pop) r_din <= w_head;
      case (r_state)
        S_IDLE:  if (!w_empty) r_state <= S_BUSY;
        S_BUSY:  if (tx_done_tick && !r_tx_start && w_empty) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_start   = r_tx_start;
  assign din        = r_din;
  assign fifo_count = w_count;
endmodule

// File: tb/tb_tx_pixel_packer.sv
module tb_tx_pixel_packer;
  localparam int DEPTH = 16;
`ifdef FRAME_MARKER_EN
  localparam bit MARK_EN = 1'b1;
`else
  localparam bit MARK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pix_valid = 1'b0, pix_bit = 1'b0, pix_last = 1'b0;
  logic       pix_ready, tx_start;
  logic [7:0] din;
  logic       tx_done_tick = 1'b0;
  logic [4:0] fifo_count;

  tx_pixel_packer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_bit(pix_bit),
    .pix_last(pix_last), .pix_ready(pix_ready), .tx_start(tx_start),
    .din(din), .tx_done_tick(tx_done_tick), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: records every load, answers with a tick auto_dly
  // cycles after tx_start when enabled.
  logic [7:0] rx_q[$];
  int         ts_q[$];
  int         tk_q[$];
  bit         auto_en = 1'b0;
  int         auto_dly = 4;
  int         dbl_start = 0;

  initial begin
    bit pend, prev;
    int cnt;
    pend = 0; prev = 0; cnt = 0;
    forever begin
      @(negedge clk);
      tx_done_tick = 1'b0;
      if (!reset) pend = 0;
      else if (tx_start) begin
        rx_q.push_back(din);
        ts_q.push_back(cyc);
        pend = 1; cnt = 0;
        if (prev) dbl_start++;
      end else if (pend && auto_en) begin
        cnt++;
        if (cnt >= auto_dly) begin
          tx_done_tick = 1'b1;
          tk_q.push_back(cyc);
          pend = 0;
        end
      end
      prev = tx_start;
    end
  end

  int n_vec = 0, n_err = 0, ridx = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rx_at(input int i);
    return (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] ts_at(input int i);
    return (i < ts_q.size()) ? ts_q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic wait_rx(input int n, input string nm);
    int g = 0;
    while (rx_q.size() < n && g < 4000) begin @(negedge clk); g++; end
    if (rx_q.size() < n) begin
      n_vec++; n_err++;
      $display("FAIL %s: timeout, got %0d bytes, expected %0d", nm, rx_q.size(), n);
    end
  endtask

  // Called at a negedge; returns at the negedge after the pixel transferred.
  task automatic put_pix(input logic b, input logic last);
    int g = 0;
    pix_valid = 1'b1; pix_bit = b; pix_last = last;
    while (!pix_ready && g < 2000) begin @(negedge clk); g++; end
    if (!pix_ready) begin
      n_vec++; n_err++;
      $display("FAIL pix_ready_timeout: got 0, expected 1");
    end
    @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n, input bit last);
    for (int i = 0; i < n; i++) put_pix(bits[i], last && (i == n - 1));
    pix_valid = 1'b0; pix_last = 1'b0; pix_bit = 1'b0;
  endtask

  // FIFO empty and sender idle on entry: checks push-to-tx_start latency.
  task automatic send_byte_timed(input logic [7:0] b, input string nm);
    int c;
    for (int i = 0; i < 7; i++) put_pix(b[i], 1'b0);
    c = cyc;
    put_pix(b[7], 1'b0);
    pix_valid = 1'b0;
    chk({nm, "_count"}, {27'h0, fifo_count}, 32'd1);
    wait_rx(ridx + 1, nm);
    chk({nm, "_lat"}, ts_at(ridx), c + 2);
    chk({nm, "_din"}, rx_at(ridx), {24'h0, b});
    ridx++;
  endtask

  typedef struct {
    int          n;
    logic [15:0] bits;
    bit          last;
    int          nexp;
    logic [2:0][7:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int nb, tb0, sb;
    vecs[0] = '{3,  16'h0007, 1'b1, 1, {8'h00, 8'h00, 8'h07}};
    vecs[1] = '{8,  16'h00F0, 1'b0, 1, {8'h00, 8'h00, 8'hF0}};
    vecs[2] = '{8,  16'h003C, 1'b1, 1, {8'h00, 8'h00, 8'h3C}};
    vecs[3] = '{10, 16'h03FF, 1'b1, 2, {8'h00, 8'h03, 8'hFF}};
    vecs[4] = '{1,  16'h0000, 1'b1, 1, {8'h00, 8'h00, 8'h00}};
    vecs[5] = '{16, 16'h1234, 1'b0, 2, {8'h00, 8'h12, 8'h34}};
    if (MARK_EN)
      for (int v = 0; v < 6; v++)
        if (vecs[v].last) begin
          vecs[v].exp[vecs[v].nexp] = 8'hA5;
          vecs[v].nexp++;
        end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx_start", {31'h0, tx_start}, 32'd0);
    chk("rst_din", {24'h0, din}, 32'd0);
    chk("rst_count", {27'h0, fifo_count}, 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'h0, pix_ready}, 32'd1);

    // Full byte 1,0,1,1,0,0,0,1 -> 8'h8D, tx_start two cycles after push
    auto_en = 1'b1; auto_dly = 4;
    send_byte_timed(8'h8D, "full_byte");
    repeat (10) @(negedge clk);

    // Table of frames, including partial flushes
    for (int v = 0; v < 6; v++) begin
      send_bits({16'h0, vecs[v].bits}, vecs[v].n, vecs[v].last);
      wait_rx(ridx + vecs[v].nexp, $sformatf("vec%0d", v));
      for (int k = 0; k < vecs[v].nexp; k++) begin
        chk($sformatf("vec%0d_b%0d", v, k), rx_at(ridx), {24'h0, vecs[v].exp[k]});
        ridx++;
      end
    end
    repeat (10) @(negedge clk);

    // pix_ready in the cycle after pix_last
    send_bits(32'h3, 2, 1'b1);
    chk("ready_after_last", {31'h0, pix_ready}, MARK_EN ? 32'd0 : 32'd1);
    @(negedge clk);
    chk("ready_after_last2", {31'h0, pix_ready}, 32'd1);
    wait_rx(ridx + (MARK_EN ? 2 : 1), "last2");
    chk("last2_b0", rx_at(ridx), 32'h03); ridx++;
    if (MARK_EN) begin chk("last2_mark", rx_at(ridx), 32'hA5); ridx++; end
    repeat (10) @(negedge clk);

    // Backpressure: transmitter stalled, FIFO fills, nothing lost
    auto_en = 1'b0;
    nb = MARK_EN ? DEPTH : DEPTH + 1;
    for (int i = 0; i < nb; i++) begin
      logic [7:0] b;
      b = 8'(i * 29 + 17);
      for (int k = 0; k < 8; k++) put_pix(b[k], 1'b0);
    end
    pix_valid = 1'b0;
    chk("bp_count", {27'h0, fifo_count}, nb - 1);
    chk("bp_ready", {31'h0, pix_ready}, 32'd0);
    auto_en = 1'b1; auto_dly = 3;
    wait_rx(ridx + nb, "bp_drain");
    for (int i = 0; i < nb; i++) begin
      chk($sformatf("bp_b%0d", i), rx_at(ridx), {24'h0, 8'(i * 29 + 17)});
      ridx++;
    end
    repeat (10) @(negedge clk);

    // Back-to-back: three queued bytes, tick every 160 cycles
    auto_en = 1'b0;
    send_bits(32'h000F_5AC3, 24, 1'b0);
    repeat (4) @(negedge clk);
    chk("b2b_count", {27'h0, fifo_count}, 32'd2);
    tb0 = tk_q.size(); sb = ts_q.size();
    auto_dly = 160; auto_en = 1'b1;
    begin
      int g = 0;
      while (tk_q.size() < tb0 + 3 && g < 1000) begin @(negedge clk); g++; end
    end
    repeat (10) @(negedge clk);
    chk("b2b_ticks", tk_q.size(), tb0 + 3);
    chk("b2b_start1", ts_at(sb), (tk_q.size() > tb0) ? tk_q[tb0] + 1 : -1);
    chk("b2b_start2", ts_at(sb + 1), (tk_q.size() > tb0 + 1) ? tk_q[tb0 + 1] + 1 : -1);
    chk("b2b_no_more", ts_q.size(), sb + 2);
    chk("b2b_b0", rx_at(ridx), 32'hC3);
    chk("b2b_b1", rx_at(ridx + 1), 32'h5A);
    chk("b2b_b2", rx_at(ridx + 2), 32'h0F);
    ridx += 3;
    auto_dly = 4;
    send_byte_timed(8'h96, "idle_again");
    repeat (10) @(negedge clk);

    // Reset mid-operation: byte in flight, two queued, five pixels packed
    auto_en = 1'b0;
    send_bits(32'h1F24_4281, 29, 1'b0);
    repeat (3) @(negedge clk);
    chk("prerst_count", {27'h0, fifo_count}, 32'd2);
    wait_rx(ridx + 1, "prerst");
    chk("prerst_b0", rx_at(ridx), 32'h81); ridx++;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("midrst_count", {27'h0, fifo_count}, 32'd0);
    chk("midrst_tx_start", {31'h0, tx_start}, 32'd0);
    chk("midrst_din", {24'h0, din}, 32'd0);
    chk("midrst_ready", {31'h0, pix_ready}, 32'd1);
    sb = ts_q.size();
    repeat (6) @(negedge clk);
    chk("midrst_no_start", ts_q.size(), sb);
    auto_en = 1'b1;
    send_bits(32'h6B, 8, 1'b0);
    wait_rx(ridx + 1, "postrst");
    chk("postrst_b0", rx_at(ridx), 32'h6B); ridx++;
    repeat (10) @(negedge clk);
    chk("rx_total", rx_q.size(), ridx);
    chk("tx_start_gap", dbl_start, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/tx_pixel_packer.md
# tx_pixel_packer

Upstream feeder for the UART transmitter. Accepts the binarized pixel stream from the systolic threshold array one bit per pixel. Packs eight pixels into a byte, buffers bytes in a small FIFO, and drives the transmitter's `tx_start`/`din` inputs, pacing itself on `tx_done_tick`. Frames of arbitrary pixel count are supported: a partial final byte is flushed zero-padded.

## Interface
- `DEPTH`, 16: FIFO depth in bytes; power of two, ≥4.
- `MARKER`, 8'hA5: end-of-frame marker byte; used only with `FRAME_MARKER_EN`.
- `clk`, input, 1: system clock; all logic is on the rising edge.
- `reset`, input, 1: reset is synchronous and active-low. It is sampled on `clk`, and `reset`=0 clears the block.
- `pix_valid`, input, 1: pixel present on `pix_bit`.
- `pix_bit`, input, 1: binarized pixel (1 = white).
- `pix_last`, input, 1: qualifies the last pixel of a frame.
- `pix_ready`, output, 1: block accepts a pixel this cycle. A transfer occurs when `pix_valid` and `pix_ready` are both high.
- `tx_start`, output, 1: one-cycle request to the transmitter.
- `din`, output, 8: byte to transmit; valid whenever `tx_start` is high and held until the next load.
- `tx_done_tick`, input, 1: transmitter finished its stop bit.
- `fifo_count`, output, $clog2(DEPTH)+1: bytes currently buffered.

## Operation
- **Packer**
  - 8-bit shift register `pk` and 3-bit index `pidx`.
  - Pixel k of a byte goes to bit k, LSB first, so pixels leave the UART line in arrival order.
  - On transfer, write `pix_bit` into `pk[pidx]`.
  - When `pidx`==7, or when `pix_last` is high, push `pk` (with the current bit merged) to the FIFO. Unwritten bits are 0. Then clear `pk` and set `pidx` to 0.
  - `pidx` wraps 7→0 on every push.
- **FIFO**
  - Synchronous, DEPTH entries.
  - A simultaneous push and pop leaves `fifo_count` unchanged.
  - A push is never attempted when full; this is guaranteed by `pix_ready`.
- **`pix_ready` rule**
  - High when free entries ≥1, or ≥2 with `FRAME_MARKER_EN`.
  - Evaluated from registered `fifo_count` only, with no combinational path from `pix_valid`.
- **Sender FSM**, states `S_IDLE`, `S_BUSY`:
  - `S_IDLE`: if the FIFO is non-empty, pop the head into `din`, pulse `tx_start` on the next cycle, and go to `S_BUSY`.
  - `S_BUSY`: wait for `tx_done_tick`.
    - On the tick with the FIFO non-empty: pop, load `din`, pulse `tx_start` on the next cycle, and stay in `S_BUSY`.
    - On the tick with the FIFO empty: go to `S_IDLE`.
  - `tx_done_tick` in `S_IDLE` is ignored.
- **Reset** (`reset`=0 at a clock edge, any state, including mid-byte or mid-transmission):
  - `pk`=0, `pidx`=0, FIFO emptied, FSM=`S_IDLE`.
  - `tx_start`=0, `din`=8'h00, `fifo_count`=0.
  - `pix_ready`=1 from the first cycle after reset is released.
  - A partially packed byte is discarded.

## Timing
- `tx_start` is a registered single-cycle pulse and is never high on two consecutive cycles.
- `din` changes only in the cycle `tx_start` rises.
- Pixel-to-FIFO latency: a byte completed at edge N is visible in `fifo_count` after edge N.
- First byte out: with the FIFO empty in `S_IDLE`, a push at edge N gives `tx_start` high in cycle N+2.
- Back-to-back bytes: `tx_done_tick` in cycle T gives the next `tx_start` in cycle T+1. At that point the transmitter is already idle.
- Throughput: one pixel per cycle, limited only by `pix_ready`.

## Configuration
- Macro `FRAME_MARKER_EN`.
- **Defined:** after the byte pushed by `pix_last`, the packer pushes `MARKER` into the FIFO on the next cycle.
  - `pix_ready` is low during that cycle.
  - The host receives data bytes followed by `MARKER` for each frame.
- **Undefined:**
  - No marker is generated.
  - `pix_ready` uses the ≥1-free rule.
  - `MARKER` is unused.

## Structure
- Shared package `uart_pkg`:
  - sender state enum (`S_IDLE`, `S_BUSY`);
  - byte width constant (8);
  - default `MARKER` value.
- Sub-module `sync_fifo`, parameterised by width and depth, exposing push, pop, head, count, full and empty. The packer and the sender FSM stay in `tx_pixel_packer`.

## Test plan
- **Full byte:** pixels 1,0,1,1,0,0,0,1 back-to-back, no `pix_last`. Expect one push with `din`=8'h8D and `tx_start` 2 cycles after the push.
- **Partial flush:** pixels 1,1,1 with `pix_last` on the third. Expect `din`=8'h07 and `pidx` back to 0.
- **Backpressure:**
  - Hold `tx_done_tick` low and stream 17×8 pixels with `pix_valid` constant.
  - Expect `fifo_count` to saturate at 16 (one byte already in `din`) and `pix_ready` low.
  - Then release ticks and expect all 17 bytes to arrive in order, with none lost.
- **Back-to-back send:** 3 bytes queued and a tick every 160 cycles. Expect each `tx_start` exactly 1 cycle after its `tx_done_tick`, and a return to `S_IDLE` after the third tick.
- **Reset mid-operation:** drive `reset`=0 for one cycle after 5 pixels and with 2 bytes queued. Expect `fifo_count`=0, no `tx_start`, and the next 8 pixels forming a fresh byte.
- **`FRAME_MARKER_EN` build:** 10 pixels of all-1 with `pix_last`. Expect bytes 8'hFF, 8'h03, 8'hA5 in that order, and `pix_ready` low for one cycle after `pix_last`.
